tlc_input_conditioner: RTL

TLC_INPUT_CONDITIONER -- requirements
Module: tlc_input_conditioner

---
 rtl/tlc_input_conditioner.sv | 67 ++++++
 1 files changed

// File: rtl/tlc_input_conditioner.sv
// tlc_input_conditioner: synchronises and debounces two vehicle sensors
// and divides the system clock down to a one-cycle enable tick.
module tlc_input_conditioner #(
   parameter int DEB_CYCLES = 16,
   parameter int TICK_DIV   = 50000000
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic sensor1_raw,
   input  logic sensor2_raw,
   output logic sensor1,
   output logic sensor2,
   output logic sensor1_rise,
   output logic sensor2_rise,
   output logic ena
);
   localparam int DW = $clog2(DEB_CYCLES);
   localparam int TW = $clog2(TICK_DIV);
   localparam logic [DW-1:0] DMAX = DW'(DEB_CYCLES - 1);
   localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);
   logic [1:0] raw, meta, sync, deb, rise;
   logic [DW-1:0] cnt [2];
   logic [TW-1:0] tcnt;
   assign raw = {sensor2_raw, sensor1_raw};
   assign sensor1 = deb[0];
   assign sensor2 = deb[1];
   assign sensor1_rise = rise[0];
   assign sensor2_rise = rise[1];
   // rise is registered alongside deb so it lines up with the first cycle deb reads 1
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            meta[i] <= 1'b0;
            sync[i] <= 1'b0;
            deb[i]  <= 1'b0;
            rise[i] <= 1'b0;
            cnt[i]  <= '0;
         end else begin
            meta[i] <= raw[i];
            sync[i] <= meta[i];
            if (sync[i] == deb[i]) begin
               cnt[i]  <= '0;
               rise[i] <= 1'b0;
            end else if (cnt[i] == DMAX) begin
               cnt[i]  <= '0;
               deb[i]  <= sync[i];
               rise[i] <= sync[i];
            end else begin
               cnt[i]  <= cnt[i] + 1'b1;
               rise[i] <= 1'b0;
            end
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         tcnt <= '0;
         ena  <= 1'b0;
      end else if (run) begin
         tcnt <= (tcnt == TMAX) ? '0 : tcnt + 1'b1;
         ena  <= (tcnt == TMAX);
      end else begin
         ena  <= 1'b0;
      end
   end
endmodule
